// File: rtl/rr_arbiter16_pkg.sv
// Shared definitions for the 16-way round-robin arbiter (package arb_pkg).
// Optional feature macro used elsewhere in this slice: ARB_LOCK_EN.
package arb_pkg;

  localparam int N_REQ = 16;
  localparam int IDX_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // One-hot decode of a requester index.
  function automatic logic [N_REQ-1:0] idx_to_oh(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_arbiter16_if.sv
// Request/grant bundle between the 16 requesters and rr_arbiter16.
// Macro ARB_LOCK_EN adds the lock signal.
//
// Handshake: req[i] asks for the resource; a grant is held while gnt_vld is
// high (req is not looked at during a grant) and ends on the cycle after the
// granted requester drives done high, or after the watchdog fires (timeout
// pulse). A new grant always follows a one-cycle idle bubble.
interface rr_arbiter16_if
  import arb_pkg::*;
  ();

  logic [N_REQ-1:0] req;
  logic             done;
`ifdef ARB_LOCK_EN
  logic             lock;
`endif
  logic             gnt_vld;
  logic [IDX_W-1:0] gnt_idx;
  logic [N_REQ-1:0] gnt_oh;
  logic             timeout;
  arb_state_t       dbg_state;

  // Requester side.
  modport master (
    output req,
    output done,
`ifdef ARB_LOCK_EN
    output lock,
`endif
    input  gnt_vld,
    input  gnt_idx,
    input  gnt_oh,
    input  timeout,
    input  dbg_state
  );

  // Arbiter side.
  modport slave (
    input  req,
    input  done,
`ifdef ARB_LOCK_EN
    input  lock,
`endif
    output gnt_vld,
    output gnt_idx,
    output gnt_oh,
    output timeout,
    output dbg_state
  );

endinterface

// File: rtl/rr_arbiter16_pick.sv
// rr_pick16: combinational round-robin search. Finds the first set bit of req
// starting at ptr+1 and wrapping modulo 16, so requester ptr is checked last.
module rr_pick16
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] pick_idx,
  output logic             any
);

  logic [IDX_W-1:0] cand;

  // Walk the 16 positions after ptr; first hit wins.
  always_comb begin
    pick_idx = '0;
    any      = 1'b0;
    cand     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = ptr + IDX_W'(i + 1);
      if (!any && req[cand]) begin
        any      = 1'b1;
        pick_idx = cand;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter16.sv
// rr_arbiter16: 16-requester round-robin arbiter with hold-until-done grants,
// registered index/one-hot grant outputs and a watchdog that revokes a grant
// held for TIMEOUT cycles without done (TIMEOUT = 0 disables it).
// Macro ARB_LOCK_EN: done with lock high keeps the current grant.
module rr_arbiter16
  import arb_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  rr_arbiter16_if.slave  bus
);

  localparam bit               WDOG_EN  = (TIMEOUT > 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  arb_state_t       state_q, state_d;
  logic             gnt_vld_q, gnt_vld_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic [N_REQ-1:0] gnt_oh_q, gnt_oh_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             lock_in;
  logic             expire;

`ifdef ARB_LOCK_EN
  assign lock_in = bus.lock;
`else
  assign lock_in = 1'b0;
`endif

  // gnt_idx doubles as the round-robin pointer, so the last served requester
  // is searched last.
  rr_pick16 u_pick (
    .req      (bus.req),
    .ptr      (gnt_idx_q),
    .pick_idx (pick_idx),
    .any      (pick_any)
  );

  assign expire = WDOG_EN && (cnt_q == CNT_LAST);

  // Next-state, pointer, watchdog and registered-output computation.
  always_comb begin
    state_d   = state_q;
    gnt_idx_d = gnt_idx_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d   = GRANT;
          gnt_idx_d = pick_idx;
          cnt_d     = '0;
        end
      end
      GRANT: begin
        if (bus.done) begin
          // done beats a simultaneous watchdog expiry.
          if (lock_in) begin
            cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else if (expire) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    gnt_vld_d = (state_d == GRANT);
    gnt_oh_d  = gnt_vld_d ? idx_to_oh(gnt_idx_d) : '0;
  end

  // All state and outputs registered; asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_vld_q <= 1'b0;
      gnt_idx_q <= 4'hF;
      gnt_oh_q  <= '0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_vld_q <= gnt_vld_d;
      gnt_idx_q <= gnt_idx_d;
      gnt_oh_q  <= gnt_oh_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.gnt_vld   = gnt_vld_q;
  assign bus.gnt_idx   = gnt_idx_q;
  assign bus.gnt_oh    = gnt_oh_q;
  assign bus.timeout   = timeout_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_rr_arbiter16.sv
// Directed testbench for rr_arbiter16 (TIMEOUT=4). The lock scenario runs
// only when ARB_LOCK_EN is defined.
module tb_rr_arbiter16;
  import arb_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  rr_arbiter16_if bus ();

  rr_arbiter16 #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_grant(input string tag, input logic [3:0] idx);
    check({tag, ".vld"}, 32'(bus.gnt_vld), 32'd1);
    check({tag, ".idx"}, 32'(bus.gnt_idx), 32'(idx));
    check({tag, ".oh"},  32'(bus.gnt_oh),  32'd1 << idx);
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".vld"}, 32'(bus.gnt_vld), 32'd0);
    check({tag, ".oh"},  32'(bus.gnt_oh),  32'd0);
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst_n    = 1'b0;
    bus.req  = '0;
    bus.done = 1'b0;
`ifdef ARB_LOCK_EN
    bus.lock = 1'b0;
`endif

    // Reset state.
    tick();
    tick();
    check("rst.vld", 32'(bus.gnt_vld), 32'd0);
    check("rst.idx", 32'(bus.gnt_idx), 32'hF);
    check("rst.oh", 32'(bus.gnt_oh), 32'd0);
    check("rst.timeout", 32'(bus.timeout), 32'd0);
    check("rst.state", 32'(bus.dbg_state), 32'(IDLE));
    rst_n = 1'b1;
    tick();
    check_idle("rst.quiet");

    // Single requester 0: grant, release, re-grant after one bubble.
    bus.req = 16'h0001;
    tick();
    check_grant("single.g1", 4'd0);
    check("single.state", 32'(bus.dbg_state), 32'(GRANT));
    bus.done = 1'b1;
    tick();
    check_idle("single.bubble");
    bus.done = 1'b0;
    tick();
    check_grant("single.g2", 4'd0);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    bus.req  = '0;
    check_idle("single.rel");

    // Full rotation with everyone requesting; pointer is at 0 here.
    bus.req = 16'hFFFF;
    for (int i = 0; i < 17; i++) begin
      tick();
      check_grant($sformatf("rot.g%0d", i), 4'((i + 1) % 16));
      bus.done = 1'b1;
      tick();
      check_idle($sformatf("rot.b%0d", i));
      bus.done = 1'b0;
    end
    bus.req = '0;

    // Pointer fairness: serve 5, then 0821 gives 11, 0, 5.
    bus.req = 16'h0020;
    tick();
    check_grant("fair.g5", 4'd5);
    bus.req = 16'h0821;
    tick();
    check_grant("fair.hold_ignores_req", 4'd5);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    tick();
    check_grant("fair.g11", 4'd11);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    tick();
    check_grant("fair.g0", 4'd0);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    tick();
    check_grant("fair.g5b", 4'd5);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    bus.req  = '0;

    // Watchdog expiry: grant 8 held 4 cycles, then one-cycle timeout pulse.
    bus.req = 16'h0100;
    tick();
    check_grant("wd.c0", 4'd8);
    bus.req = '0;
    tick();
    check_grant("wd.c1", 4'd8);
    tick();
    check_grant("wd.c2", 4'd8);
    tick();
    check_grant("wd.c3", 4'd8);
    check("wd.c3.timeout", 32'(bus.timeout), 32'd0);
    tick();
    check_idle("wd.exp");
    check("wd.exp.timeout", 32'(bus.timeout), 32'd1);
    tick();
    check("wd.after.timeout", 32'(bus.timeout), 32'd0);
    check_idle("wd.after");

    // done on the expiry cycle wins: no timeout pulse.
    bus.req = 16'h0100;
    tick();
    check_grant("wdd.c0", 4'd8);
    bus.req = '0;
    tick();
    tick();
    tick();
    check_grant("wdd.c3", 4'd8);
    bus.done = 1'b1;
    tick();
    check_idle("wdd.rel");
    check("wdd.rel.timeout", 32'(bus.timeout), 32'd0);
    // done while idle is ignored.
    tick();
    check("wdd.idle_done.timeout", 32'(bus.timeout), 32'd0);
    check_idle("wdd.idle_done");
    check("wdd.idle_done.ptr", 32'(bus.gnt_idx), 32'd8);
    bus.done = 1'b0;

    // Asynchronous reset mid-grant; afterwards lowest set bit wins.
    bus.req = 16'h0210;
    tick();
    check_grant("ar.g9", 4'd9);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("ar.async");
    check("ar.async.idx", 32'(bus.gnt_idx), 32'hF);
    tick();
    rst_n = 1'b1;
    tick();
    check_grant("ar.g4", 4'd4);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    bus.req  = '0;

`ifdef ARB_LOCK_EN
    // Lock: grant 3, done+lock keeps it and restarts the watchdog.
    tick();
    bus.req = 16'h0008;
    tick();
    check_grant("lk.g3", 4'd3);
    bus.req  = 16'h0048;
    bus.done = 1'b1;
    bus.lock = 1'b1;
    tick();
    check_grant("lk.kept", 4'd3);
    bus.done = 1'b0;
    bus.lock = 1'b0;
    tick();
    tick();
    tick();
    check_grant("lk.wd_restarted", 4'd3);
    check("lk.timeout", 32'(bus.timeout), 32'd0);
    bus.done = 1'b1;
    tick();
    check_idle("lk.rel");
    bus.done = 1'b0;
    tick();
    check_grant("lk.next6", 4'd6);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    bus.req  = '0;
`endif

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_arbiter16.md
# rr_arbiter16

Round-robin arbiter that shares one datapath resource (register-file write port, memory bus) among 16 requesters. It grants one requester at a time with a hold-until-done handshake. Grant is presented both as a 4-bit index and as a one-hot 16-bit vector, so it can drive the select and enable lines of the shared resource directly. A watchdog revokes a grant that is never released.

## Interface
- `TIMEOUT`, default 64: cycles a grant may be held without `done`; 0 disables the watchdog.
- `CNT_W`, default 8: width of the watchdog counter; must satisfy `TIMEOUT < 2**CNT_W`.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous assert, active-low.
- `req` input 16: request vector, bit i = requester i.
- `done` input 1: granted requester releases the grant this cycle.
- `lock` input 1: keep the current grant after `done`; present only when `ARB_LOCK_EN` is defined.
- `gnt_vld` output 1: a grant is active.
- `gnt_idx` output 4: index of the granted requester; valid when `gnt_vld` is high.
- `gnt_oh` output 16: one-hot grant equal to `1 << gnt_idx` when `gnt_vld` is high, otherwise all zeros.
- `timeout` output 1: one-cycle pulse when the watchdog revokes a grant.

## Operation
- There are two states, IDLE and GRANT.
- **Reset values:** state IDLE, `gnt_vld`=0, `gnt_idx`=4'hF, `gnt_oh`=0, `timeout`=0, watchdog counter 0.
  - `gnt_idx` resets to 4'hF so that requester 0 has first priority.
- **IDLE:**
  - If `req` is nonzero, pick the first set bit searching upward from `gnt_idx+1`, wrapping modulo 16.
  - Register the pick into `gnt_idx` and move to GRANT.
  - If `req` is zero, stay in IDLE and keep `gnt_idx` as the round-robin pointer.
- **GRANT:**
  - `gnt_vld`=1 and `gnt_oh` is decoded from `gnt_idx`.
  - `req` is ignored; deasserting `req[gnt_idx]` does not release the grant.
  - The watchdog counter increments every cycle in GRANT and clears on entry to GRANT.
- **GRANT to IDLE on `done`:** `gnt_idx` is retained as the pointer, so the just-served requester gets lowest priority next time.
- **GRANT to IDLE on watchdog:** if `TIMEOUT`≠0 and the counter equals `TIMEOUT-1` with `done` low, go to IDLE and pulse `timeout` for one cycle.
- **Boundary cases:**
  - `done` and watchdog expiry in the same cycle: `done` wins and there is no `timeout` pulse.
  - `done` while in IDLE: ignored.
  - All 16 requesting: grants proceed 0,1,…,15,0 with no starvation.
  - Single requester: it is re-granted after each one-cycle IDLE bubble.
  - `rst_n` asserted mid-grant: all outputs drop to reset values immediately (asynchronously).

## Timing
- `req` sampled in IDLE at cycle t gives `gnt_vld`/`gnt_idx`/`gnt_oh` high at t+1.
- `done` at cycle t drops `gnt_vld` at t+1. The next grant appears at t+2 at the earliest, a mandatory one-cycle bubble.
- Watchdog: a grant asserted at cycle g expires at cycle g+TIMEOUT-1. `gnt_vld` is low and `timeout` is high at g+TIMEOUT.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `ARB_LOCK_EN` defined:
  - The `lock` port exists.
  - `done` with `lock` high keeps the arbiter in GRANT with the same `gnt_idx` and clears the watchdog counter; there is no bubble.
  - `done` with `lock` low behaves normally.
  - `lock` without `done` has no effect.
- `ARB_LOCK_EN` undefined: the `lock` port is absent and every `done` releases the grant.

## Structure
- Shared package `arb_pkg`:
  - constant `N_REQ`=16
  - constant `IDX_W`=4
  - state enum `arb_state_t` {IDLE, GRANT}
- Sub-module `rr_pick16`: combinational rotate-and-priority search. Inputs are `req[15:0]` and `ptr[3:0]`; outputs are `pick_idx[3:0]` and `any`.
- The top module holds the FSM, the pointer/grant registers, the watchdog counter and the one-hot decode.

## Test plan
- **Reset then single request:** reset, then `req`=16'h0001 → `gnt_idx`=0, `gnt_oh`=16'h0001 one cycle after `req`. `done` → `gnt_vld`=0, and re-grant of 0 after the one-cycle bubble.
- **Full rotation:** `req`=16'hFFFF held, `done` pulsed each grant → `gnt_idx` sequence 0,1,2,…,15,0 with a bubble between each.
- **Pointer fairness:** after serving 5, `req`=16'h0821 → next grant is 11, then 0, then 5.
- **Watchdog:** `TIMEOUT`=4, `req`=16'h0100, no `done` → grant idx 8 for 4 cycles, then `gnt_vld`=0 with `timeout`=1 for exactly one cycle. A separate run with `done` on the expiry cycle → no `timeout` pulse.
- **Async reset mid-grant:** `rst_n` low during GRANT → `gnt_vld`/`gnt_oh` drop to 0 without waiting for a clock edge. After release, the first grant goes to the lowest set `req` bit.
- **Lock (with `ARB_LOCK_EN`):** idx 3 granted, `done`+`lock` → `gnt_idx` stays 3 with no bubble and the watchdog restarted. A later `done` without `lock` → release and the next requester is granted.
